// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch program-counter unit.
package pc_pkg;

    // Redirect classes in ascending priority; numeric order is used for comparisons.
    typedef enum logic [2:0] {
        NONE = 3'd0,
        BR   = 3'd1,
        JMP  = 3'd2,
        ERET = 3'd3,
        EXC  = 3'd4
    } redir_cls_t;

    // Two-state fetch control: IDLE holds ce low until the first edge after reset.
    typedef logic [0:0] pc_state_t;
    localparam pc_state_t IDLE = 1'b0;
    localparam pc_state_t RUN  = 1'b1;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;

endpackage

// File: rtl/pc_unit_if.sv
// Bundle of redirect inputs and fetch outputs between the pipeline and pc_unit.
interface pc_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              stall;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              jmp;
    logic [ADDR_W-1:0] jmp_target;
    logic              exc;
    logic              eret;
    logic [ADDR_W-1:0] epc;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next_seq;
    logic              ce;
    logic              redirect_pending;
    logic              misalign;

    // Pipeline side: drives redirects, observes fetch address.
    modport master (
        output stall, br_taken, br_target, jmp, jmp_target, exc, eret, epc,
        input  pc, pc_next_seq, ce, redirect_pending, misalign
    );

    // PC unit side.
    modport slave (
        input  stall, br_taken, br_target, jmp, jmp_target, exc, eret, epc,
        output pc, pc_next_seq, ce, redirect_pending, misalign
    );
endinterface

// File: rtl/pc_redirect_arb.sv
// Combinational priority pick among live redirect inputs and the buffered entry.
module pc_redirect_arb
    import pc_pkg::*;
#(
    parameter int unsigned           ADDR_W      = 32,
    parameter int unsigned           INSTR_BYTES = 4,
    parameter logic [ADDR_W-1:0]     EXC_VECTOR  = ADDR_W'(DEF_EXC_VECTOR)
) (
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              jmp_i,
    input  logic [ADDR_W-1:0] jmp_target_i,
    input  logic              exc_i,
    input  logic              eret_i,
    input  logic [ADDR_W-1:0] epc_i,
    input  redir_cls_t        pend_cls_i,
    input  logic [ADDR_W-1:0] pend_tgt_i,
    output redir_cls_t        live_cls_o,
    output logic [ADDR_W-1:0] live_tgt_o,
    output redir_cls_t        win_cls_o,
    output logic [ADDR_W-1:0] win_tgt_o,
    output logic              misalign_o
);

    localparam logic [ADDR_W-1:0] LowMask = ADDR_W'(INSTR_BYTES - 1);

    logic [ADDR_W-1:0] raw_tgt;

    // Highest-priority live request.
    always_comb begin
        live_cls_o = NONE;
        live_tgt_o = '0;
        if (exc_i) begin
            live_cls_o = EXC;
            live_tgt_o = EXC_VECTOR;
        end else if (eret_i) begin
            live_cls_o = ERET;
            live_tgt_o = epc_i;
        end else if (jmp_i) begin
            live_cls_o = JMP;
            live_tgt_o = jmp_target_i;
        end else if (br_taken_i) begin
            live_cls_o = BR;
            live_tgt_o = br_target_i;
        end
    end

    // Buffered entry wins only if strictly above every live request.
    always_comb begin
        if (pend_cls_i > live_cls_o) begin
            win_cls_o = pend_cls_i;
            raw_tgt   = pend_tgt_i;
        end else begin
            win_cls_o = live_cls_o;
            raw_tgt   = live_tgt_o;
        end
        win_tgt_o  = raw_tgt & ~LowMask;
        misalign_o = (win_cls_o != NONE) && ((raw_tgt & LowMask) != '0);
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC generator: sequential advance, prioritised redirects, stall buffering.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       INSTR_BYTES  = 4,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(DEF_EXC_VECTOR)
) (
    input logic         clk,
    input logic         rst_n,
    pc_unit_if.slave    bus
);

    localparam logic [ADDR_W-1:0] Incr = ADDR_W'(INSTR_BYTES);

    pc_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    redir_cls_t        pend_cls_q, pend_cls_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic              misalign_q, misalign_d;

    redir_cls_t        live_cls, win_cls;
    logic [ADDR_W-1:0] live_tgt, win_tgt;
    logic              win_misalign;

    pc_redirect_arb #(
        .ADDR_W      (ADDR_W),
        .INSTR_BYTES (INSTR_BYTES),
        .EXC_VECTOR  (EXC_VECTOR)
    ) u_arb (
        .br_taken_i   (bus.br_taken),
        .br_target_i  (bus.br_target),
        .jmp_i        (bus.jmp),
        .jmp_target_i (bus.jmp_target),
        .exc_i        (bus.exc),
        .eret_i       (bus.eret),
        .epc_i        (bus.epc),
        .pend_cls_i   (pend_cls_q),
        .pend_tgt_i   (pend_tgt_q),
        .live_cls_o   (live_cls),
        .live_tgt_o   (live_tgt),
        .win_cls_o    (win_cls),
        .win_tgt_o    (win_tgt),
        .misalign_o   (win_misalign)
    );

    // Next-state: IDLE->RUN once; in RUN hold+buffer on stall, else load or advance.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_cls_d = pend_cls_q;
        pend_tgt_d = pend_tgt_q;
        misalign_d = 1'b0;
        if (state_q == IDLE) begin
            state_d = RUN;
        end else if (bus.stall) begin
            // An exception entry is sticky; otherwise equal or higher class replaces.
            if (live_cls != NONE && pend_cls_q != EXC && live_cls >= pend_cls_q) begin
                pend_cls_d = live_cls;
                pend_tgt_d = live_tgt;
            end
        end else begin
            pend_cls_d = NONE;
            pend_tgt_d = '0;
            if (win_cls != NONE) begin
                pc_d       = win_tgt;
                misalign_d = win_misalign;
            end else begin
                pc_d = pc_q + Incr;
            end
        end
    end

    // State, PC and pending registers; reset discards any buffered redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VECTOR;
            pend_cls_q <= NONE;
            pend_tgt_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_cls_q <= pend_cls_d;
            pend_tgt_q <= pend_tgt_d;
            misalign_q <= misalign_d;
        end
    end

    // Outputs.
    always_comb begin
        bus.pc               = pc_q;
        bus.pc_next_seq      = pc_q + Incr;
        bus.ce               = (state_q == RUN);
        bus.redirect_pending = (pend_cls_q != NONE);
        bus.misalign         = misalign_q;
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (32-bit and 8-bit instances).
module tb_pc_unit;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    pc_unit_if #(.ADDR_W(32)) bus32 ();
    pc_unit_if #(.ADDR_W(8))  bus8 ();

    pc_unit #(
        .ADDR_W       (32),
        .INSTR_BYTES  (4),
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (32'h0000_0180)
    ) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32)
    );

    pc_unit #(
        .ADDR_W       (8),
        .INSTR_BYTES  (4),
        .RESET_VECTOR (8'h00),
        .EXC_VECTOR   (8'h80)
    ) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear32();
        bus32.stall = 0; bus32.br_taken = 0; bus32.jmp = 0; bus32.exc = 0; bus32.eret = 0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        clear32();
        bus32.br_target = '0; bus32.jmp_target = '0; bus32.epc = '0;
        bus8.stall = 0; bus8.br_taken = 0; bus8.jmp = 0; bus8.exc = 0; bus8.eret = 0;
        bus8.br_target = '0; bus8.jmp_target = '0; bus8.epc = '0;

        // Reset state.
        #3;
        check_eq("rst_pc", bus32.pc, 32'h0);
        check_eq("rst_ce", bus32.ce, 1'b0);
        check_eq("rst_pend", bus32.redirect_pending, 1'b0);
        check_eq("rst_mis", bus32.misalign, 1'b0);
        rst_n = 1'b1;

        // First edge: IDLE->RUN, pc still at reset vector.
        tick();
        check_eq("run_ce", bus32.ce, 1'b1);
        check_eq("run_pc0", bus32.pc, 32'h0);
        check_eq("run_seq0", bus32.pc_next_seq, 32'h4);
        tick(); check_eq("seq_4", bus32.pc, 32'h4);
        tick(); check_eq("seq_8", bus32.pc, 32'h8);
        tick(); check_eq("seq_c", bus32.pc, 32'hc);

        // Reach 0x40, then exc beats jmp and br.
        bus32.jmp = 1; bus32.jmp_target = 32'h40;
        tick(); check_eq("jmp_40", bus32.pc, 32'h40);
        bus32.exc = 1; bus32.jmp_target = 32'h100; bus32.br_taken = 1; bus32.br_target = 32'h200;
        tick(); check_eq("exc_prio", bus32.pc, 32'h180);
        clear32();
        bus32.eret = 1; bus32.epc = 32'h44;
        tick(); check_eq("eret", bus32.pc, 32'h44);
        clear32();

        // Stall 3 cycles with a branch in cycle 1.
        bus32.stall = 1; bus32.br_taken = 1; bus32.br_target = 32'h300;
        tick(); check_eq("stall_hold1", bus32.pc, 32'h44);
        check_eq("stall_pend1", bus32.redirect_pending, 1'b1);
        bus32.br_taken = 0;
        tick(); tick();
        check_eq("stall_hold3", bus32.pc, 32'h44);
        check_eq("stall_pend3", bus32.redirect_pending, 1'b1);
        bus32.stall = 0;
        tick(); check_eq("rel_pc", bus32.pc, 32'h300);
        check_eq("rel_pend", bus32.redirect_pending, 1'b0);
        tick(); check_eq("rel_seq", bus32.pc, 32'h304);

        // br then jmp during stall: jmp replaces.
        bus32.stall = 1; bus32.br_taken = 1; bus32.br_target = 32'h300;
        tick(); bus32.br_taken = 0; bus32.jmp = 1; bus32.jmp_target = 32'h500;
        tick(); clear32();
        tick(); check_eq("br_then_jmp", bus32.pc, 32'h500);
        tick(); check_eq("after_500", bus32.pc, 32'h504);

        // jmp then br: br does not replace.
        bus32.stall = 1; bus32.jmp = 1; bus32.jmp_target = 32'h500;
        tick(); bus32.jmp = 0; bus32.br_taken = 1; bus32.br_target = 32'h300;
        tick(); clear32();
        tick(); check_eq("jmp_then_br", bus32.pc, 32'h500);

        // Buffered exc survives its deassertion and a later jmp.
        bus32.stall = 1; bus32.exc = 1;
        tick(); check_eq("exc_stall_hold", bus32.pc, 32'h500);
        bus32.exc = 0; bus32.jmp = 1; bus32.jmp_target = 32'h700;
        tick(); clear32();
        tick(); check_eq("exc_buffered", bus32.pc, 32'h180);

        // 8-bit instance: wrap and misalignment.
        bus8.jmp = 1; bus8.jmp_target = 8'hfc;
        tick(); bus8.jmp = 0;
        check_eq("w8_fc", bus8.pc, 8'hfc);
        check_eq("w8_seq_wrap", bus8.pc_next_seq, 8'h00);
        tick(); check_eq("w8_wrap", bus8.pc, 8'h00);
        bus8.jmp = 1; bus8.jmp_target = 8'h13;
        tick(); bus8.jmp = 0;
        check_eq("w8_align", bus8.pc, 8'h10);
        check_eq("w8_mis1", bus8.misalign, 1'b1);
        tick(); check_eq("w8_mis0", bus8.misalign, 1'b0);
        check_eq("w8_14", bus8.pc, 8'h14);

        // Reset mid-stall with a pending exc.
        bus32.stall = 1; bus32.exc = 1;
        tick(); bus32.exc = 0;
        check_eq("pre_rst_pend", bus32.redirect_pending, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_pc", bus32.pc, 32'h0);
        check_eq("arst_ce", bus32.ce, 1'b0);
        check_eq("arst_pend", bus32.redirect_pending, 1'b0);
        rst_n = 1'b1;
        // Redirects and stall are ignored in IDLE.
        bus32.jmp = 1; bus32.jmp_target = 32'h900;
        tick(); clear32();
        check_eq("restart_ce", bus32.ce, 1'b1);
        check_eq("restart_pc", bus32.pc, 32'h0);
        tick(); check_eq("restart_seq", bus32.pc, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
